// File: rtl/data_mem_arbiter.sv
// Data-memory port arbiter: shares one RAM port between the MEM stage and the UART loader,
// sequencing each access through IDLE/ISSUE/WAIT/DONE to cover the RAM's fixed read latency.
module data_mem_arbiter #(
   parameter int unsigned ISA_WIDTH     = 32,
   parameter int unsigned READ_LATENCY  = 2,
   parameter int unsigned MEM_WRITE_BIT = 1,
   parameter int unsigned MEM_READ_BIT  = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           cpu_mem_control,
   input  logic                 cpu_no_op,
   input  logic [ISA_WIDTH-1:0] cpu_addr,
   input  logic [ISA_WIDTH-1:0] cpu_wdata,
   output logic [ISA_WIDTH-1:0] cpu_rdata,
   output logic                 mem_stall,
   input  logic                 ldr_valid,
   input  logic [ISA_WIDTH-1:0] ldr_addr,
   input  logic [ISA_WIDTH-1:0] ldr_wdata,
   output logic                 ldr_ready,
   output logic                 ram_en,
   output logic                 ram_we,
   output logic [ISA_WIDTH-1:0] ram_addr,
   output logic [ISA_WIDTH-1:0] ram_wdata,
   input  logic [ISA_WIDTH-1:0] ram_rdata
);

   localparam int unsigned CNT_W = 3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_LDR = 1'b1
   } owner_t;

   state_t               state_q, state_d;
   owner_t               owner_q, owner_d;
   owner_t               last_owner_q, last_owner_d;
   logic                 is_rd_q, is_rd_d;
   logic [CNT_W-1:0]     lat_cnt_q, lat_cnt_d;
   logic [ISA_WIDTH-1:0] addr_q, addr_d;
   logic [ISA_WIDTH-1:0] wdata_q, wdata_d;
   logic [ISA_WIDTH-1:0] rdata_q, rdata_d;

   logic cpu_req;
   logic cpu_is_rd;

   assign cpu_req   = ~cpu_no_op & (cpu_mem_control != 2'b00);
   // A write request takes precedence over a simultaneous read request.
   assign cpu_is_rd = cpu_mem_control[MEM_READ_BIT] & ~cpu_mem_control[MEM_WRITE_BIT];

   assign cpu_rdata = rdata_q;
   assign ldr_ready = (state_q == S_DONE) & (owner_q == OWN_LDR);
   assign mem_stall = cpu_req & ~((state_q == S_DONE) & (owner_q == OWN_CPU));

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         owner_q      <= OWN_CPU;
         last_owner_q <= OWN_LDR;
         is_rd_q      <= 1'b0;
         lat_cnt_q    <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         is_rd_q      <= is_rd_d;
         lat_cnt_q    <= lat_cnt_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
      end
   end

   // Next-state, grant and RAM-port decode.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      is_rd_d      = is_rd_q;
      lat_cnt_d    = lat_cnt_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      ram_en       = 1'b0;
      ram_we       = 1'b0;
      ram_addr     = '0;
      ram_wdata    = '0;

      case (state_q)
         S_IDLE: begin
            // On a tie the requester that was not served last wins.
            if (cpu_req && (!ldr_valid || (last_owner_q == OWN_LDR))) begin
               owner_d = OWN_CPU;
               is_rd_d = cpu_is_rd;
               addr_d  = cpu_addr;
               wdata_d = cpu_wdata;
               state_d = S_ISSUE;
            end else if (ldr_valid) begin
               owner_d = OWN_LDR;
               is_rd_d = 1'b0;
               addr_d  = ldr_addr;
               wdata_d = ldr_wdata;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            ram_en    = 1'b1;
            ram_we    = ~is_rd_q;
            ram_addr  = addr_q;
            ram_wdata = wdata_q;
            if (is_rd_q) begin
               lat_cnt_d = CNT_W'(READ_LATENCY - 1);
               state_d   = S_WAIT;
            end else begin
               state_d   = S_DONE;
            end
         end
         S_WAIT: begin
            lat_cnt_d = lat_cnt_q - CNT_W'(1);
            if (lat_cnt_q == '0) begin
               rdata_d = ram_rdata;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            last_owner_d = owner_q;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: stores, loads, arbitration, bubbles, flush and mid-load reset,
// against a small RAM model with a two-cycle read pipeline.
module tb_data_mem_arbiter;

   localparam int unsigned W = 32;

   logic         clk;
   logic         rst;
   logic [1:0]   cpu_mem_control;
   logic         cpu_no_op;
   logic [W-1:0] cpu_addr;
   logic [W-1:0] cpu_wdata;
   logic [W-1:0] cpu_rdata;
   logic         mem_stall;
   logic         ldr_valid;
   logic [W-1:0] ldr_addr;
   logic [W-1:0] ldr_wdata;
   logic         ldr_ready;
   logic         ram_en;
   logic         ram_we;
   logic [W-1:0] ram_addr;
   logic [W-1:0] ram_wdata;
   logic [W-1:0] ram_rdata;

   int tests  = 0;
   int failed = 0;

   data_mem_arbiter #(.ISA_WIDTH(W), .READ_LATENCY(2)) dut (
      .clk(clk), .rst(rst),
      .cpu_mem_control(cpu_mem_control), .cpu_no_op(cpu_no_op),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
      .mem_stall(mem_stall),
      .ldr_valid(ldr_valid), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_ready(ldr_ready),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: read data appears two cycles after the issue cycle.
   logic [W-1:0] mem [0:63];
   logic [W-1:0] rd_p0, rd_p1;
   always @(posedge clk) begin
      if (ram_en && ram_we) mem[ram_addr[7:2]] <= ram_wdata;
      rd_p0 <= (ram_en && !ram_we) ? mem[ram_addr[7:2]] : 32'h0BAD0BAD;
      rd_p1 <= rd_p0;
   end
   assign ram_rdata = rd_p1;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      tests++;
      assert (got === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_idle_port(input string tag);
      chk({tag, "_en"}, W'(ram_en), 32'h0);
      chk({tag, "_we"}, W'(ram_we), 32'h0);
      chk({tag, "_addr"}, ram_addr, 32'h0);
      chk({tag, "_wdata"}, ram_wdata, 32'h0);
   endtask

   task automatic cpu_idle();
      cpu_mem_control = 2'b00;
      cpu_addr        = '0;
      cpu_wdata       = '0;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      rst = 1'b1; cpu_no_op = 1'b0; cpu_idle();
      ldr_valid = 1'b0; ldr_addr = '0; ldr_wdata = '0;

      // Reset state, and mem_stall follows cpu_req even under reset
      tick(); #1;
      chk_idle_port("rst");
      chk("rst_ldr_ready", W'(ldr_ready), 32'h0);
      chk("rst_stall0", W'(mem_stall), 32'h0);
      chk("rst_rdata", cpu_rdata, 32'h0);
      cpu_mem_control = 2'b10; #1;
      chk("rst_stall1", W'(mem_stall), 32'h1);
      cpu_idle();
      tick(); rst = 1'b0;

      // CPU store 0x10 <= DEADBEEF
      cpu_mem_control = 2'b10; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF; #1;
      chk("st_t0_stall", W'(mem_stall), 32'h1);
      chk_idle_port("st_t0");
      tick(); #1;
      chk("st_t1_en", W'(ram_en), 32'h1);
      chk("st_t1_we", W'(ram_we), 32'h1);
      chk("st_t1_addr", ram_addr, 32'h10);
      chk("st_t1_wdata", ram_wdata, 32'hDEADBEEF);
      chk("st_t1_stall", W'(mem_stall), 32'h1);
      tick(); #1;
      chk("st_t2_stall", W'(mem_stall), 32'h0);
      chk_idle_port("st_t2");
      tick(); cpu_idle(); #1;
      chk_idle_port("st_t3");

      // CPU load 0x10, L=2: four stall cycles, data captured for DONE
      cpu_mem_control = 2'b01; cpu_addr = 32'h10; #1;
      chk("ld_t0_stall", W'(mem_stall), 32'h1);
      tick(); #1;
      chk("ld_t1_en", W'(ram_en), 32'h1);
      chk("ld_t1_we", W'(ram_we), 32'h0);
      chk("ld_t1_addr", ram_addr, 32'h10);
      chk("ld_t1_stall", W'(mem_stall), 32'h1);
      tick(); #1;
      chk("ld_t2_stall", W'(mem_stall), 32'h1);
      chk("ld_t2_en", W'(ram_en), 32'h0);
      tick(); #1;
      chk("ld_t3_stall", W'(mem_stall), 32'h1);
      chk("ld_t3_rdata", cpu_rdata, 32'h0);
      tick(); #1;
      chk("ld_t4_stall", W'(mem_stall), 32'h0);
      chk("ld_t4_rdata", cpu_rdata, 32'hDEADBEEF);
      tick(); cpu_idle(); #1;
      chk("ld_t5_rdata", cpu_rdata, 32'hDEADBEEF);
      tick(); #1;
      chk("ld_t6_rdata", cpu_rdata, 32'hDEADBEEF);

      // Re-reset, then CPU load and loader write in the same cycle: CPU first
      rst = 1'b1; #1;
      chk("rr_rdata", cpu_rdata, 32'h0);
      tick(); rst = 1'b0;
      cpu_mem_control = 2'b01; cpu_addr = 32'h10;
      ldr_valid = 1'b1; ldr_addr = 32'h40; ldr_wdata = 32'hA5A5A5A5; #1;
      chk("tie_t0_stall", W'(mem_stall), 32'h1);
      tick(); #1;
      chk("tie_t1_addr", ram_addr, 32'h10);
      chk("tie_t1_we", W'(ram_we), 32'h0);
      chk("tie_t1_ready", W'(ldr_ready), 32'h0);
      tick(); tick(); tick(); #1;
      chk("tie_t4_stall", W'(mem_stall), 32'h0);
      chk("tie_t4_rdata", cpu_rdata, 32'hDEADBEEF);
      chk("tie_t4_ready", W'(ldr_ready), 32'h0);
      tick(); cpu_idle(); #1;
      chk("tie_t5_stall", W'(mem_stall), 32'h0);
      chk("tie_t5_en", W'(ram_en), 32'h0);
      tick(); #1;
      chk("tie_t6_en", W'(ram_en), 32'h1);
      chk("tie_t6_we", W'(ram_we), 32'h1);
      chk("tie_t6_addr", ram_addr, 32'h40);
      chk("tie_t6_wdata", ram_wdata, 32'hA5A5A5A5);
      chk("tie_t6_stall", W'(mem_stall), 32'h0);
      chk("tie_t6_ready", W'(ldr_ready), 32'h0);
      tick(); #1;
      chk("tie_t7_ready", W'(ldr_ready), 32'h1);
      chk("tie_t7_stall", W'(mem_stall), 32'h0);
      tick(); ldr_valid = 1'b0; #1;
      chk("tie_t8_ready", W'(ldr_ready), 32'h0);
      chk("tie_t8_en", W'(ram_en), 32'h0);

      // Continuous requests from both sides: grants alternate CPU, LDR, CPU, LDR
      cpu_mem_control = 2'b10; cpu_addr = 32'h100; cpu_wdata = 32'h1;
      ldr_valid = 1'b1; ldr_addr = 32'h104; ldr_wdata = 32'h2;
      for (int g = 0; g < 4; g++) begin
         tick(); #1;
         chk($sformatf("alt%0d_en", g), W'(ram_en), 32'h1);
         chk($sformatf("alt%0d_addr", g), ram_addr, (g % 2 == 0) ? 32'h100 : 32'h104);
         tick(); #1;
         chk($sformatf("alt%0d_ready", g), W'(ldr_ready), (g % 2 == 0) ? 32'h0 : 32'h1);
         chk($sformatf("alt%0d_stall", g), W'(mem_stall), (g % 2 == 0) ? 32'h0 : 32'h1);
         tick(); #1;
      end
      cpu_idle(); ldr_valid = 1'b0;
      tick(); #1;
      chk("alt_end_en", W'(ram_en), 32'h0);

      // Bubble with both control bits set: no access, no stall
      cpu_no_op = 1'b1; cpu_mem_control = 2'b11; cpu_addr = 32'h30; cpu_wdata = 32'h55; #1;
      chk("nop_stall", W'(mem_stall), 32'h0);
      tick(); #1;
      chk("nop_en1", W'(ram_en), 32'h0);
      tick(); #1;
      chk("nop_en2", W'(ram_en), 32'h0);

      // Both bits set without bubble: a single write, no read capture
      cpu_no_op = 1'b0; #1;
      chk("rw_stall", W'(mem_stall), 32'h1);
      tick(); #1;
      chk("rw_en", W'(ram_en), 32'h1);
      chk("rw_we", W'(ram_we), 32'h1);
      chk("rw_addr", ram_addr, 32'h30);
      tick(); #1;
      chk("rw_done_stall", W'(mem_stall), 32'h0);
      chk("rw_rdata", cpu_rdata, 32'hDEADBEEF);
      tick(); cpu_idle(); #1;
      chk("rw_after_en", W'(ram_en), 32'h0);

      // Reset during WAIT of a load: abandoned with no capture
      rst = 1'b1; tick(); rst = 1'b0;
      cpu_mem_control = 2'b01; cpu_addr = 32'h10;
      tick(); tick(); #1;
      chk("rw_wait_stall", W'(mem_stall), 32'h1);
      rst = 1'b1; #1;
      chk_idle_port("wrst");
      chk("wrst_stall", W'(mem_stall), 32'h1);
      chk("wrst_rdata", cpu_rdata, 32'h0);
      chk("wrst_ready", W'(ldr_ready), 32'h0);
      cpu_idle(); #1;
      chk("wrst_stall0", W'(mem_stall), 32'h0);
      tick(); tick(); rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick(); #1;
         chk($sformatf("post_rst%0d_rdata", c), cpu_rdata, 32'h0);
         chk($sformatf("post_rst%0d_en", c), W'(ram_en), 32'h0);
      end

      // Flush: cpu_req drops while the CPU store is in ISSUE; write still happens, no stall
      cpu_mem_control = 2'b10; cpu_addr = 32'h50; cpu_wdata = 32'h77;
      tick(); cpu_idle(); #1;
      chk("fl_en", W'(ram_en), 32'h1);
      chk("fl_we", W'(ram_we), 32'h1);
      chk("fl_addr", ram_addr, 32'h50);
      chk("fl_wdata", ram_wdata, 32'h77);
      chk("fl_stall", W'(mem_stall), 32'h0);
      tick(); #1;
      chk("fl_done_stall", W'(mem_stall), 32'h0);
      chk("fl_done_en", W'(ram_en), 32'h0);
      tick(); #1;
      chk("fl_mem", mem[5'h14], 32'h77);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
